wb_mem_stream_writer: RTL

Wishbone memory-bus master that drains a word stream into memory. It sits on the m1 (secondary master) port of arbiter_2_masters, in front of wb_bram, and is the master that occupies the mem_o_* bus. A peripheral core (for example, the Prometheus data path) pushes 32-bit words into an internal FIFO. The block writes them to consecutive word addresses starting at a programmed base address and signals completion.

---
 rtl/wb_mem_stream_writer.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_mem_stream_writer.sv
// Wishbone master draining a pushed word stream into consecutive memory words.
// Optional macro WB_MEM_WRITER_TIMEOUT_EN adds an ack timeout that sets the sticky o_err.

module wb_mem_stream_writer_fifo #(
   parameter int AW = 3,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DW-1:0] dat_i,
   input  logic          pop_i,
   output logic [DW-1:0] dat_o,
   output logic          empty_o,
   output logic          full_nxt_o
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)
         cnt_d = '0;
      else if (push_i && !pop_i)
         cnt_d = cnt_q + CNT_ONE;
      else if (!push_i && pop_i)
         cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
         end else begin
            if (push_i) wr_q <= wr_q + PTR_ONE;
            if (pop_i)  rd_q <= rd_q + PTR_ONE;
         end
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i)
         mem_q[wr_q] <= dat_i;
   end

   assign dat_o      = mem_q[rd_q];
   assign empty_o    = (cnt_q == '0);
   assign full_nxt_o = (cnt_d == CNT_FULL);
endmodule

module wb_mem_stream_writer #(
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int TIMEOUT         = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [31:0] i_base_adr,
   input  logic [23:0] i_len,
   input  logic        i_abort,
   input  logic        i_stb,
   input  logic [31:0] i_data,
   output logic        o_rdy,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [23:0] o_count,
   output logic        o_mem_we,
   output logic        o_mem_stb,
   output logic        o_mem_cyc,
   output logic [3:0]  o_mem_sel,
   output logic [31:0] o_mem_adr,
   output logic [31:0] o_mem_dat,
   input  logic [31:0] i_mem_dat,
   input  logic        i_mem_ack,
   input  logic        i_mem_int
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_WRITE, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [23:0] len_q, len_d, count_q, count_d, pushes_q, pushes_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d, rdy_q, rdy_d;
   logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d;

   logic        push, pop, flush;
   logic [31:0] fifo_head;
   logic        fifo_empty, fifo_full_nxt;

   logic unused_inputs;
   assign unused_inputs = ^{i_mem_dat, i_mem_int};

`ifdef WB_MEM_WRITER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          timeout_hit;
   assign timeout_hit = (to_cnt_q == TW'(TIMEOUT - 1));
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

   assign push = i_stb & rdy_q;

   wb_mem_stream_writer_fifo #(.AW(FIFO_DEPTH_LOG2), .DW(32)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .push_i     (push),
      .dat_i      (i_data),
      .pop_i      (pop),
      .dat_o      (fifo_head),
      .empty_o    (fifo_empty),
      .full_nxt_o (fifo_full_nxt)
   );

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      count_d  = count_q;
      pushes_d = pushes_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cyc_d    = cyc_q;
      stb_d    = stb_q;
      we_d     = we_q;
      sel_d    = sel_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      pop      = 1'b0;
      flush    = 1'b0;
`ifdef WB_MEM_WRITER_TIMEOUT_EN
      to_cnt_d = (state_q == S_WRITE && !i_mem_ack) ? to_cnt_q + TW'(1) : '0;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               count_d  = '0;
               pushes_d = '0;
               err_d    = 1'b0;
               base_d   = i_base_adr;
               len_d    = i_len;
               if (i_len != '0) begin
                  busy_d  = 1'b1;
                  state_d = S_WAIT_DATA;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT_DATA: begin
            if (i_abort) begin
               {cyc_d, stb_d, we_d} = 3'b000;
               sel_d   = '0;
               flush   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (!fifo_empty) begin
               {cyc_d, stb_d, we_d} = 3'b111;
               sel_d   = 4'hF;
               adr_d   = base_q + {8'd0, count_q};
               dat_d   = fifo_head;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (i_mem_ack) begin
               // The acked word is counted even when an abort lands in the same cycle.
               pop     = 1'b1;
               count_d = count_q + 24'd1;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = '0;
               if (i_abort) begin
                  cyc_d   = 1'b0;
                  flush   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else if (count_q + 24'd1 == len_q) begin
                  cyc_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_DATA;
               end
            end else if (i_abort) begin
               {cyc_d, stb_d, we_d} = 3'b000;
               sel_d   = '0;
               flush   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
`ifdef WB_MEM_WRITER_TIMEOUT_EN
            end else if (timeout_hit) begin
               {cyc_d, stb_d, we_d} = 3'b000;
               sel_d   = '0;
               flush   = 1'b1;
               err_d   = 1'b1;
               state_d = S_DONE;
`endif
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push)
         pushes_d = pushes_q + 24'd1;
      rdy_d = busy_d & ~fifo_full_nxt & (pushes_d != len_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         count_q  <= '0;
         pushes_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdy_q    <= 1'b0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
`ifdef WB_MEM_WRITER_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         count_q  <= count_d;
         pushes_q <= pushes_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdy_q    <= rdy_d;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
`ifdef WB_MEM_WRITER_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
`endif
      end
   end

   assign o_rdy     = rdy_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_err     = err_q;
   assign o_count   = count_q;
   assign o_mem_we  = we_q;
   assign o_mem_stb = stb_q;
   assign o_mem_cyc = cyc_q;
   assign o_mem_sel = sel_q;
   assign o_mem_adr = adr_q;
   assign o_mem_dat = dat_q;
endmodule
